prefix_sum_stage: RTL and testbench

- Pipelined final-sum stage that sits directly downstream of the generated prefix tree in the multiplier datapath.
- Takes the two reduced partial-product rows plus the per-block group generate/propagate produced by the prefix tree.
- Resolves the block carry-ins and forms the final product bits.
- Registered valid/ready handshake on both sides; also flags any mismatch between the supplied group G/P and a locally recomputed G/P, as a built-in tree checker.

---
 rtl/prefix_sum_stage_if.sv | 31 +++
 rtl/prefix_sum_stage.sv | 109 ++++++++++
 tb/tb_prefix_sum_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_sum_stage_if.sv
// Handshake bundle for the final-sum stage: operand/tree inputs, result outputs,
// and the sticky tree-checker flag.
interface prefix_sum_stage_if #(
  parameter int BLK  = 4,
  parameter int NGRP = 4
) ();
  localparam int WIDTH = BLK * NGRP;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             gp_err;

  modport master (
    output in_valid, in_a, in_b, in_cin, grp_g, grp_p, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, gp_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, grp_g, grp_p, out_ready,
    output in_ready, out_valid, out_sum, out_cout, gp_err
  );
endinterface

// File: rtl/prefix_sum_stage.sv
// Two-stage final adder behind the prefix tree: S1 resolves block carries from the
// supplied group G/P and cross-checks them; S2 forms the block sums.
module prefix_sum_stage #(
  parameter int BLK  = 4,
  parameter int NGRP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  prefix_sum_stage_if.slave bus
);
  localparam int WIDTH = BLK * NGRP;

  // Reference group {g,p} of one block with zero carry-in.
  function automatic logic [1:0] ref_gp(input logic [BLK-1:0] a, input logic [BLK-1:0] b);
    logic c;
    c = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
    end
    return {c, &(a ^ b)};
  endfunction

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [NGRP-1:0]  carry_r;
  logic             cout_r;
  logic             mm_r;
  logic             s1_valid_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_cout_r;
  logic             out_valid_r;
  logic             gp_err_r;

  logic [NGRP:0]    carry_s;
  logic             mm_s;
  logic [WIDTH-1:0] sum_s;
  logic             s1_adv_s;
  logic             accept_s;

  assign s1_adv_s      = s1_valid_r & (~out_valid_r | bus.out_ready);
  assign bus.in_ready  = ~s1_valid_r | ~out_valid_r | bus.out_ready;
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_cout  = out_cout_r;
  assign bus.gp_err    = gp_err_r;

  // Carry ripple over groups using the supplied G/P, plus the tree cross-check.
  always_comb begin
    carry_s    = '0;
    mm_s       = 1'b0;
    carry_s[0] = bus.in_cin;
    for (int k = 0; k < NGRP; k++) begin
      carry_s[k+1] = bus.grp_g[k] | (bus.grp_p[k] & carry_s[k]);
      if (ref_gp(bus.in_a[k*BLK +: BLK], bus.in_b[k*BLK +: BLK]) != {bus.grp_g[k], bus.grp_p[k]}) begin
        mm_s = 1'b1;
      end else begin
        mm_s = mm_s;
      end
    end
  end

  // Per-block sums with the registered block carry-ins.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < NGRP; k++) begin
      sum_s[k*BLK +: BLK] = a_r[k*BLK +: BLK] + b_r[k*BLK +: BLK]
                          + {{(BLK-1){1'b0}}, carry_r[k]};
    end
  end

  // S1 capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      carry_r    <= '0;
      cout_r     <= 1'b0;
      mm_r       <= 1'b0;
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      a_r        <= bus.in_a;
      b_r        <= bus.in_b;
      carry_r    <= carry_s[NGRP-1:0];
      cout_r     <= carry_s[NGRP];
      mm_r       <= mm_s;
      s1_valid_r <= 1'b1;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Output register; gp_err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_r   <= '0;
      out_cout_r  <= 1'b0;
      out_valid_r <= 1'b0;
      gp_err_r    <= 1'b0;
    end else if (s1_adv_s) begin
      out_sum_r   <= sum_s;
      out_cout_r  <= cout_r;
      out_valid_r <= 1'b1;
      gp_err_r    <= gp_err_r | mm_r;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prefix_sum_stage.sv
// Scoreboard bench for prefix_sum_stage: directed tree/carry cases, stalls, mid-flight
// reset and a randomized sweep against an arithmetic reference model.
module tb_prefix_sum_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prefix_sum_stage_if #(.BLK(4), .NGRP(4)) bus ();
  prefix_sum_stage #(.BLK(4), .NGRP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   received = 0;
  logic err_exp = 1'b0;
  logic saw_stall = 1'b0;
  logic rnd_mode = 1'b0;
  logic force_ready = 1'b1;
  logic rnd_bit = 1'b1;
  logic [15:0] held_sum;
  logic        held_cout;
  logic        held_v = 1'b0;

  assign bus.out_ready = rnd_mode ? rnd_bit : force_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // Reference: block carries come from the supplied G/P; mismatch uses plain block arithmetic.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [3:0] g, input logic [3:0] p, output exp_t e);
    int c;
    int ak;
    int bk;
    logic mm;
    c = int'(cin);
    mm = 1'b0;
    e.sum = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      ak = int'(a[k*4 +: 4]);
      bk = int'(b[k*4 +: 4]);
      e.sum[k*4 +: 4] = 4'((ak + bk + c) % 16);
      if (((ak + bk) >= 16) != g[k] || ((ak ^ bk) == 15) != p[k]) mm = 1'b1;
      c = (g[k] || (p[k] && c != 0)) ? 1 : 0;
    end
    e.cout = (c != 0);
    if (!mm) {e.cout, e.sum} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    err_exp = err_exp | mm;
    e.err = err_exp;
  endtask

  task automatic gen(output logic [15:0] a, output logic [15:0] b, output logic cin,
                     output logic [3:0] g, output logic [3:0] p);
    a = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       b = ~a;
      1:       b = 16'h0000 - a;
      default: b = 16'($urandom);
    endcase
    cin = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      g[k] = (int'(a[k*4 +: 4]) + int'(b[k*4 +: 4])) >= 16;
      p[k] = (a[k*4 +: 4] ^ b[k*4 +: 4]) == 4'hF;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [3:0] g, input logic [3:0] p);
    logic acc;
    int n;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = cin;
    bus.grp_g = g; bus.grp_p = p;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 1000) begin
      #1;
      acc = bus.in_ready;
      if (!acc) saw_stall = 1'b1;
      @(posedge clk);
      if (!acc) @(negedge clk);
      n++;
    end
    if (acc) begin
      model(a, b, cin, g, p, e);
      q.push_back(e);
    end else begin
      checks++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_gp_err", bus.gp_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
  endtask

  always @(negedge clk) rnd_bit <= 1'($urandom);

  // Monitor: pops the scoreboard on each transfer and checks hold during stalls.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bus.out_valid) begin
      if (held_v) begin
        chk("stall_hold", {15'h0, bus.out_cout, bus.out_sum}, {15'h0, held_cout, held_sum});
      end
      if (bus.out_ready) begin
        held_v = 1'b0;
        received++;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got sum %h with nothing pending", bus.out_sum);
        end else begin
          e = q.pop_front();
          chk("sum", bus.out_sum, e.sum);
          chk("cout", bus.out_cout, e.cout);
          chk("gp_err", bus.gp_err, e.err);
        end
      end else begin
        held_v = 1'b1;
        held_sum = bus.out_sum;
        held_cout = bus.out_cout;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic cin;
    logic [3:0] g;
    logic [3:0] p;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.grp_g = '0; bus.grp_p = '0;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_sum", bus.out_sum, 0);
    chk("reset_gp_err", bus.gp_err, 0);
    do_reset();

    send(16'h00FF, 16'h0001, 1'b0, 4'b0001, 4'b0010);
    send(16'hFFFF, 16'h0000, 1'b1, 4'b0000, 4'b1111);
    drain();
    chk("clean_gp_err", bus.gp_err, 0);

    // Corrupted tree output: carry from block 0 is lost and the flag must latch.
    send(16'h00FF, 16'h0001, 1'b0, 4'b0000, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      gen(a, b, cin, g, p);
      send(a, b, cin, g, p);
    end
    drain();
    chk("sticky_gp_err", bus.gp_err, 1);

    do_reset();
    saw_stall = 1'b0;
    received = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          gen(a, b, cin, g, p);
          send(a, b, cin, g, p);
        end
      end
      begin
        repeat (3) @(negedge clk);
        force_ready = 1'b0;
        repeat (4) @(negedge clk);
        force_ready = 1'b1;
      end
    join
    drain();
    chk("stall_in_ready_dropped", saw_stall, 1);
    chk("stall_beat_count", received, 8);

    send(16'h1234, 16'h4321, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_gp_err", bus.gp_err, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    repeat (5) @(negedge clk);
    send(16'h8000, 16'h8000, 1'b1, 4'b1000, 4'b0000);
    drain();

    rnd_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      gen(a, b, cin, g, p);
      send(a, b, cin, g, p);
    end
    drain();
    rnd_mode = 1'b0;
    chk("sweep_gp_err", bus.gp_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
